// File: rtl/stage_skid_reg.sv
// stage_skid_reg: two-entry pipeline register with a skid slot.
// The output side can be stalled by one bit of a lock vector, and a flush
// empties the stage. in_ready comes only from registered state, which breaks
// the combinational ready path from downstream.
module stage_skid_reg #(
  parameter int DW       = 32,
  parameter int LOCK_W   = 5,
  parameter int LOCK_BIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [LOCK_W-1:0] lock,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [1:0]        count
);

  // The state encoding is also the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [DW-1:0] r_main;
  logic [DW-1:0] r_skid;
  logic [DW-1:0] w_main_next;
  logic [DW-1:0] w_skid_next;

  logic w_in_ready;
  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;
  logic w_stall;

  // Only lock[LOCK_BIT] matters to this stage. The reduction gives the other
  // bits a reader so they are not reported as unused.
  logic w_unused_lock;
  assign w_unused_lock = ^lock;

  assign w_stall     = lock[LOCK_BIT];
  assign w_in_ready  = (r_state != FULL);
  assign w_out_valid = (r_state != EMPTY);
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & out_ready & ~w_stall;

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main;
  assign count     = r_state;

  // State register. An asynchronous reset empties the stage at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Payload registers. These are zeroed on reset so that out_data reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      r_main <= w_main_next;
      r_skid <= w_skid_next;
    end
  end

  // Next-state and data-movement decode. Flush overrides all other activity.
  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main;
    w_skid_next  = r_skid;
    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_main_next  = in_data;
          w_state_next = ONE;
        end
      end
      ONE: begin
        case ({w_in_fire, w_out_fire})
          2'b10: begin
            w_skid_next  = in_data;
            w_state_next = FULL;
          end
          2'b01: begin
            w_state_next = EMPTY;
          end
          2'b11: begin
            w_main_next  = in_data;
            w_state_next = ONE;
          end
          default: begin
            w_state_next = ONE;
          end
        endcase
      end
      FULL: begin
        // in_ready is low here, so an in_fire cannot happen in this state.
        if (w_out_fire) begin
          w_main_next  = r_skid;
          w_state_next = ONE;
        end
      end
      default: begin
        w_state_next = EMPTY;
      end
    endcase
    // A payload that arrives during a flush is dropped. The stored data is
    // left as it was, because it becomes invisible once the stage is empty.
    if (flush) begin
      w_state_next = EMPTY;
      w_main_next  = r_main;
      w_skid_next  = r_skid;
    end
  end

endmodule
